// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory port bundle for dmem_lsu.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable while valid && !ready.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wData;
    logic        mem_writeEnable;
    logic [1:0]  mem_dsize;
    logic [31:0] mem_rData;

    // Pipeline and dmem side
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wData, mem_writeEnable, mem_dsize
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rData,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wData, mem_writeEnable, mem_dsize
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one request at a time, checks size/alignment/range, drives one dmem cycle.
// Optional LSU_STATS_EN adds saturating load/store/error completion counters.
module dmem_lsu #(
    parameter int unsigned DMEM_SIZE = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_lsu_if.slave   bus,
    output logic [1:0]  dbg_state
`ifdef LSU_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic        accept, resp_done, req_err;
    logic [32:0] end_addr;
    logic [31:0] wdata_mask, load_ext;

    assign accept    = (state == S_IDLE) && bus.req_valid;
    assign resp_done = (state == S_RESP) && bus.resp_ready;

    // Numeric bit n here is bit 31-n in MSB-is-bit-0 numbering; the byte at addr sits in [31:24].
    assign end_addr = {1'b0, bus.req_addr} + 33'(bus.req_size) + 33'd1;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'd2) req_err = 1'b1;
        if (bus.req_size == 2'd1 && bus.req_addr[0]) req_err = 1'b1;
        if (bus.req_size == 2'd3 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (end_addr > 33'(DMEM_SIZE)) req_err = 1'b1;
    end

    always_comb begin
        case (bus.req_size)
            2'd3:    wdata_mask = bus.req_wdata;
            2'd1:    wdata_mask = {16'h0, bus.req_wdata[15:0]};
            default: wdata_mask = {24'h0, bus.req_wdata[7:0]};
        endcase
    end

    always_comb begin
        case (size_q)
            2'd3:    load_ext = bus.mem_rData;
            2'd1:    load_ext = {{16{signed_q & bus.mem_rData[31]}}, bus.mem_rData[31:16]};
            default: load_ext = {{24{signed_q & bus.mem_rData[31]}}, bus.mem_rData[31:24]};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (bus.resp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state so reset drops strobes without a clock edge
    always_comb begin
        bus.req_ready       = (state == S_IDLE);
        bus.resp_valid      = (state == S_RESP);
        bus.resp_err        = (state == S_RESP) && err_q;
        bus.mem_writeEnable = (state == S_ACCESS) && write_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                err_q    <= req_err;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr;
                wdata_q  <= wdata_mask;
                rdata_q  <= 32'h0;
            end else if (state == S_ACCESS) begin
                rdata_q <= write_q ? 32'h0 : load_ext;
            end else if (resp_done) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wData  = wdata_q;
    assign bus.mem_dsize  = size_q;
    assign bus.resp_rdata = rdata_q;
    assign dbg_state      = state;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= 16'h0;
            stat_stores <= 16'h0;
            stat_errs   <= 16'h0;
        end else if (resp_done) begin
            if (err_q) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (write_q) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule
